// File: rtl/interleaved_modmul_pkg.sv
// Shared types and constants for the interleaved modular multiplier.
package modmul_pkg;
  localparam int WIDTH_DEFAULT = 16;
  localparam int IDX_W = $clog2(WIDTH_DEFAULT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DBL  = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } modmul_state_t;
endpackage

// File: rtl/interleaved_modmul_if.sv
// Operand/result handshake bundle between the multiplier and its neighbours.
interface interleaved_modmul_if
  import modmul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] m;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             out_err;
  logic             busy;

  modport master (
    output in_valid, a, b, m, out_ready,
    input  in_ready, out_valid, result, out_err, busy
  );

  modport slave (
    input  in_valid, a, b, m, out_ready,
    output in_ready, out_valid, result, out_err, busy
  );
endinterface

// File: rtl/interleaved_modmul_bk_adder.sv
// Brent-Kung parallel-prefix adder; W must be a power of two.
module bk_adder #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);
  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W-1:0] h;

  assign h = a_i ^ b_i;

  // g[i] ends up as the carry out of bit i (carry-in folded into bit 0).
  always_comb begin
    g    = a_i & b_i;
    p    = h;
    g[0] = g[0] | (p[0] & cin_i);
    for (int d = 1; d < W; d = d * 2) begin
      for (int i = 2 * d - 1; i < W; i += 2 * d) begin
        g[i] = g[i] | (p[i] & g[i-d]);
        p[i] = p[i] & p[i-d];
      end
    end
    for (int d = W / 4; d > 0; d = d / 2) begin
      for (int i = 3 * d - 1; i < W; i += 2 * d) begin
        g[i] = g[i] | (p[i] & g[i-d]);
        p[i] = p[i] & p[i-d];
      end
    end
  end

  assign sum_o  = h ^ {g[W-2:0], cin_i};
  assign cout_o = g[W-1];
endmodule

// File: rtl/interleaved_modmul_reduce.sv
// Combinational (x + y) mod m for x, y < m: one add pass, one conditional-subtract pass.
module modmul_reduce_step #(
  parameter int W = 16
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  logic [W-1:0] m_i,
  output logic [W-1:0] r_o
);
  logic [W-1:0] sum1;
  logic [W-1:0] diff;
  logic         c_sum;
  logic         c_diff;
  logic         ge;

  bk_adder #(.W(W)) u_add (
    .a_i   (x_i),
    .b_i   (y_i),
    .cin_i (1'b0),
    .sum_o (sum1),
    .cout_o(c_sum)
  );

  bk_adder #(.W(W)) u_sub (
    .a_i   (sum1),
    .b_i   (~m_i),
    .cin_i (1'b1),
    .sum_o (diff),
    .cout_o(c_diff)
  );

  // Bit W of {c_sum,sum1} + {1,~m} + 1 carries out exactly when the 17-bit sum >= m.
  assign ge  = c_sum | c_diff;
  assign r_o = ge ? diff : sum1;
endmodule

// File: rtl/interleaved_modmul.sv
// Radix-2 interleaved modular multiplier: result = (a * b) mod m, MSB first.
//   state | meaning
//   IDLE  | waiting for operands, in_ready high
//   DBL   | R = 2R mod m
//   ADD   | R = (R + b[i]*a) mod m, step to next bit or finish
//   DONE  | result/out_err held with out_valid until out_ready
module interleaved_modmul
  import modmul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input logic                  clk,
  input logic                  rst_n,
  interleaved_modmul_if.slave  bus
);
  modmul_state_t    state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] red;

  assign addend = (state_q == DBL) ? r_q : (b_q[idx_q] ? a_q : '0);

  modmul_reduce_step #(.W(WIDTH)) u_step (
    .x_i(r_q),
    .y_i(addend),
    .m_i(m_q),
    .r_o(red)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      r_q      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      r_q      <= r_d;
      result_q <= result_d;
      err_q    <= err_d;
      idx_q    <= idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    r_d      = r_q;
    result_d = result_q;
    err_d    = err_q;
    idx_d    = idx_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d      = bus.a;
          b_d      = bus.b;
          m_d      = bus.m;
          r_d      = '0;
          idx_d    = IDX_W'(WIDTH - 1);
          result_d = '0;
          if ((bus.m == '0) || (bus.a >= bus.m)) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            state_d = DBL;
          end
        end
      end
      DBL: begin
        r_d     = red;
        state_d = ADD;
      end
      ADD: begin
        r_d = red;
        if (idx_q == '0) begin
          result_d = red;
          state_d  = DONE;
        end else begin
          idx_d   = idx_q - 1'b1;
          state_d = DBL;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q == DBL) || (state_q == ADD);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.out_err   = err_q;
endmodule

// File: tb/tb_interleaved_modmul.sv
// Directed-table and randomised checks for interleaved_modmul.
module tb_interleaved_modmul;
  localparam int LIMIT = 100;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  interleaved_modmul_if #(.WIDTH(16)) bus ();

  interleaved_modmul #(.WIDTH(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] m;
    logic [15:0] res;
    logic        err;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called #1 after a rising edge with the DUT idle; returns once out_valid is seen.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] m,
                       output logic [15:0] res, output logic err,
                       output int lat, output int bcnt);
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.m = m;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a = 16'hDEAD;
    bus.b = 16'hBEEF;
    bus.m = 16'h0BAD;
    lat  = 0;
    bcnt = 0;
    while (!bus.out_valid && lat < LIMIT) begin
      if (bus.busy) bcnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (lat >= LIMIT) begin
      total++;
      bad++;
      $display("FAIL timeout: no out_valid within %0d cycles for a=%0h b=%0h m=%0h", LIMIT, a, b, m);
    end
    res = bus.result;
    err = bus.out_err;
  endtask

  logic [15:0] res, ra, rb, rm;
  logic        err;
  int          lat, bcnt;
  logic [31:0] model;

  initial begin
    vecs[0] = '{16'd5,    16'd7,    16'd11,   16'd2,   1'b0};
    vecs[1] = '{16'hFFFE, 16'hFFFE, 16'hFFFF, 16'h1,   1'b0};
    vecs[2] = '{16'd0,    16'hFFFF, 16'h1234, 16'h0,   1'b0};
    vecs[3] = '{16'd12,   16'd3,    16'd11,   16'h0,   1'b1};
    vecs[4] = '{16'd3,    16'd3,    16'd0,    16'h0,   1'b1};
    vecs[5] = '{16'd123,  16'd456,  16'd1009, 16'd593, 1'b0};
    vecs[6] = '{16'hFFFE, 16'hFFFF, 16'hFFFF, 16'h0,   1'b0};
    vecs[7] = '{16'd7,    16'd1,    16'd8,    16'd7,   1'b0};
    vecs[8] = '{16'd11,   16'd3,    16'd11,   16'h0,   1'b1};
    vecs[9] = '{16'd0,    16'd0,    16'd1,    16'h0,   1'b0};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.m         = '0;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_result", {16'b0, bus.result}, 32'd0);
    chk("rst_err", {31'b0, bus.out_err}, 32'd0);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].m, res, err, lat, bcnt);
      chk($sformatf("vec%0d_result", i), {16'b0, res}, {16'b0, vecs[i].res});
      chk($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, vecs[i].err});
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].err ? 32'd0 : 32'd32);
      chk($sformatf("vec%0d_busy_cycles", i), bcnt, vecs[i].err ? 32'd0 : 32'd32);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid_drop", i), {31'b0, bus.out_valid}, 32'd0);
      chk($sformatf("vec%0d_in_ready", i), {31'b0, bus.in_ready}, 32'd1);
    end

    // Backpressure: result held, in_ready low, stray in_valid ignored while stalled.
    bus.out_ready = 1'b0;
    do_op(16'd9, 16'd10, 16'd13, res, err, lat, bcnt);
    chk("bp_result", {16'b0, res}, 32'd12);
    chk("bp_latency", lat, 32'd32);
    bus.in_valid = 1'b1;
    bus.a = 16'd1;
    bus.b = 16'd1;
    bus.m = 16'd2;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp_hold_valid%0d", c), {31'b0, bus.out_valid}, 32'd1);
      chk($sformatf("bp_hold_result%0d", c), {16'b0, bus.result}, 32'd12);
      chk($sformatf("bp_hold_in_ready%0d", c), {31'b0, bus.in_ready}, 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("bp_release_in_ready", {31'b0, bus.in_ready}, 32'd1);

    // Reset in the middle of an operation.
    bus.in_valid = 1'b1;
    bus.a = 16'd5;
    bus.b = 16'd7;
    bus.m = 16'd11;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    chk("mid_busy_before_rst", {31'b0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("mid_rst_result", {16'b0, bus.result}, 32'd0);
    chk("mid_rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("mid_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_op(16'd2, 16'd3, 16'd5, res, err, lat, bcnt);
    chk("post_rst_result", {16'b0, res}, 32'd1);
    chk("post_rst_err", {31'b0, err}, 32'd0);
    chk("post_rst_latency", lat, 32'd32);
    @(posedge clk);
    #1;

    // Back-to-back random operands against the arithmetic reference.
    for (int n = 0; n < 1000; n++) begin
      rm = 16'($urandom_range(1, 65535));
      ra = 16'($urandom % {16'b0, rm});
      rb = 16'($urandom_range(0, 65535));
      model = ({16'b0, ra} * {16'b0, rb}) % {16'b0, rm};
      do_op(ra, rb, rm, res, err, lat, bcnt);
      chk($sformatf("rnd%0d a=%0h b=%0h m=%0h", n, ra, rb, rm), {16'b0, res}, model);
      chk($sformatf("rnd%0d_latency", n), lat, 32'd32);
      @(posedge clk);
      #1;
      chk($sformatf("rnd%0d_in_ready", n), {31'b0, bus.in_ready}, 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
